// File: rtl/unidade_de_busca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_de_busca_pkg
//  Description : Shared ISA constants, instruction field positions and the
//                fetch-stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package unidade_de_busca_pkg;

    // Instruction field positions
    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 27;
    localparam int c_REG_MSB    = 26;
    localparam int c_REG_LSB    = 22;

    // ISA opcodes
    localparam logic [4:0] c_OP_NOP    = 5'd0;
    localparam logic [4:0] c_OP_ADD    = 5'd1;
    localparam logic [4:0] c_OP_SUB    = 5'd2;
    localparam logic [4:0] c_OP_AND    = 5'd3;
    localparam logic [4:0] c_OP_OR     = 5'd4;
    localparam logic [4:0] c_OP_XOR    = 5'd5;
    localparam logic [4:0] c_OP_LOAD   = 5'd8;
    localparam logic [4:0] c_OP_STORE  = 5'd9;
    localparam logic [4:0] c_OP_JMP    = 5'd16;
    localparam logic [4:0] c_OP_BEQ    = 5'd17;
    localparam logic [4:0] c_OPCODE_HLT = 5'd18;

    // Fetch-stage states
    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

    // Extract the opcode field of an instruction word
    function automatic logic [4:0] opcode_de(input logic [31:0] palavra);
        return palavra[c_OPCODE_MSB:c_OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_de_busca.sv
`default_nettype none
// ============================================================================
//  Module      : unidade_de_busca
//  Description : Instruction fetch stage. Owns the PC, drives the instruction
//                memory address, captures returned words into an instruction
//                register with a valid/ready handshake to decode, accepts
//                branch redirects and halts on a hlt opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module unidade_de_busca
    import unidade_de_busca_pkg::*;
#(
    parameter int                     LARGURA_END = 32,
    parameter logic [LARGURA_END-1:0] PC_INICIAL  = {{(LARGURA_END-1){1'b0}}, 1'b1},
    parameter logic [4:0]             OPCODE_HLT  = c_OPCODE_HLT
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [LARGURA_END-1:0] endereco,
    input  logic [31:0]            instrucao_mem,
    output logic [31:0]            instrucao,
    output logic [LARGURA_END-1:0] pc_atual,
    output logic                   valido,
    input  logic                   pronto,
    input  logic                   desvio,
    input  logic [LARGURA_END-1:0] alvo_desvio,
    output logic                   parado
);

    localparam logic [LARGURA_END-1:0] c_UM = {{(LARGURA_END-1){1'b0}}, 1'b1};

    estado_t                r_estado;
    logic [LARGURA_END-1:0] r_pc;
    logic [31:0]            r_instrucao;
    logic [LARGURA_END-1:0] r_pc_atual;
    logic                   r_valido;

    estado_t                w_prox_estado;
    logic [LARGURA_END-1:0] w_prox_pc;
    logic [31:0]            w_prox_instrucao;
    logic [LARGURA_END-1:0] w_prox_pc_atual;
    logic                   w_prox_valido;
    logic                   w_eh_hlt;

    assign w_eh_hlt = (opcode_de(instrucao_mem) == OPCODE_HLT);

    // State, PC and instruction register update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= INICIO;
            r_pc        <= PC_INICIAL;
            r_instrucao <= 32'd0;
            r_pc_atual  <= '0;
            r_valido    <= 1'b0;
        end else begin
            r_estado    <= w_prox_estado;
            r_pc        <= w_prox_pc;
            r_instrucao <= w_prox_instrucao;
            r_pc_atual  <= w_prox_pc_atual;
            r_valido    <= w_prox_valido;
        end
    end

    // Next-state and datapath decisions; redirect outranks capture and halt
    always_comb begin
        w_prox_estado    = r_estado;
        w_prox_pc        = r_pc;
        w_prox_instrucao = r_instrucao;
        w_prox_pc_atual  = r_pc_atual;
        w_prox_valido    = r_valido;
        case (r_estado)
            INICIO: begin
                // Memory initialises on the first clock; redirects are ignored here
                w_prox_estado = BUSCA;
            end
            BUSCA: begin
                if (desvio) begin
                    w_prox_pc     = alvo_desvio;
                    w_prox_valido = 1'b0;
                end else if (!r_valido || pronto) begin
                    w_prox_instrucao = instrucao_mem;
                    w_prox_pc_atual  = r_pc;
                    w_prox_valido    = 1'b1;
                    if (w_eh_hlt) begin
                        // PC stays on the hlt so a later reset/redirect is the only exit
                        w_prox_estado = PARADO;
                    end else begin
                        w_prox_pc = r_pc + c_UM;
                    end
                end
            end
            PARADO: begin
                if (desvio) begin
                    // Branch is older than the hlt, so it cancels the halt
                    w_prox_pc     = alvo_desvio;
                    w_prox_valido = 1'b0;
                    w_prox_estado = BUSCA;
                end else if (pronto) begin
                    w_prox_valido = 1'b0;
                end
            end
            default: begin
                w_prox_estado = INICIO;
            end
        endcase
    end

    assign endereco  = r_pc;
    assign instrucao = r_instrucao;
    assign pc_atual  = r_pc_atual;
    assign valido    = r_valido;
    assign parado    = (r_estado == PARADO);

endmodule
`default_nettype wire

// File: tb/tb_unidade_de_busca.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unidade_de_busca
//  Description : Self-checking bench for the instruction fetch stage: directed
//                vector table, PC wrap sequence and randomized run against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_de_busca;
    import unidade_de_busca_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        pronto;
    logic        desvio;
    logic [31:0] alvo_desvio;
    logic [31:0] instrucao_mem;
    logic [31:0] endereco;
    logic [31:0] instrucao;
    logic [31:0] pc_atual;
    logic        valido;
    logic        parado;

    logic [31:0] hlt_addr;
    logic        hlt_rand;

    int total = 0;
    int bad   = 0;

    unidade_de_busca #(
        .LARGURA_END(32),
        .PC_INICIAL (32'd1),
        .OPCODE_HLT (5'd18)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .endereco     (endereco),
        .instrucao_mem(instrucao_mem),
        .instrucao    (instrucao),
        .pc_atual     (pc_atual),
        .valido       (valido),
        .pronto       (pronto),
        .desvio       (desvio),
        .alvo_desvio  (alvo_desvio),
        .parado       (parado)
    );

    always #5 clock = ~clock;

    // Memory image: distinct word per address, hlt at one chosen address or,
    // in random mode, at every address congruent to 3 mod 11
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h,
                                             input logic hr);
        logic [4:0] op;
        op = 5'(a % 32'd17);
        if (a == h || (hr && (a % 32'd11) == 32'd3))
            return {5'd18, 27'd0};
        return {op, a[26:0] ^ 27'h5A5A5A5};
    endfunction

    assign instrucao_mem = mem_word(endereco, hlt_addr, hlt_rand);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        pr;
        logic        dv;
        logic [31:0] alvo;
        logic [31:0] e_end;
        logic [31:0] e_pcat;
        logic        e_v;
        logic        e_par;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic pr, input logic dv,
                                input logic [31:0] alvo, input logic [31:0] e_end,
                                input logic [31:0] e_pcat, input logic e_v,
                                input logic e_par);
        vec_t v;
        v.rst = rst; v.pr = pr; v.dv = dv; v.alvo = alvo;
        v.e_end = e_end; v.e_pcat = e_pcat; v.e_v = e_v; v.e_par = e_par;
        return v;
    endfunction

    vec_t tab[23];

    // Behavioural reference state
    logic [31:0] m_pc, m_ins, m_pcat;
    logic        m_v;
    int          m_st; // 0 idle after reset, 1 fetching, 2 halted

    task automatic model_step(input logic rst, input logic pr, input logic dv,
                              input logic [31:0] alvo);
        logic [31:0] w;
        w = mem_word(m_pc, hlt_addr, hlt_rand);
        if (rst) begin
            m_pc = 32'd1; m_ins = 32'd0; m_pcat = 32'd0; m_v = 1'b0; m_st = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (dv) begin
            m_pc = alvo; m_v = 1'b0; m_st = 1;
        end else if (m_st == 2) begin
            if (pr) m_v = 1'b0;
        end else if (!m_v || pr) begin
            m_ins = w; m_pcat = m_pc; m_v = 1'b1;
            if (w[31:27] == 5'd18) m_st = 2;
            else m_pc = m_pc + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] exp_ins;
        reset = 1'b1; pronto = 1'b0; desvio = 1'b0; alvo_desvio = 32'd0;
        hlt_addr = 32'd6; hlt_rand = 1'b0;

        //             rst pr dv alvo  end  pcat v par
        tab[0]  = mk(1, 1, 0, 0,    1,   0,  0, 0);
        tab[1]  = mk(0, 1, 0, 0,    1,   0,  0, 0);
        tab[2]  = mk(0, 1, 0, 0,    2,   1,  1, 0);
        tab[3]  = mk(0, 1, 0, 0,    3,   2,  1, 0);
        tab[4]  = mk(0, 0, 0, 0,    3,   2,  1, 0);
        tab[5]  = mk(0, 0, 0, 0,    3,   2,  1, 0);
        tab[6]  = mk(0, 0, 0, 0,    3,   2,  1, 0);
        tab[7]  = mk(0, 1, 0, 0,    4,   3,  1, 0);
        tab[8]  = mk(0, 1, 0, 0,    5,   4,  1, 0);
        tab[9]  = mk(0, 1, 0, 0,    6,   5,  1, 0);
        tab[10] = mk(0, 1, 0, 0,    6,   6,  1, 1);
        tab[11] = mk(0, 0, 0, 0,    6,   6,  1, 1);
        tab[12] = mk(0, 1, 0, 0,    6,   6,  0, 1);
        tab[13] = mk(0, 1, 0, 0,    6,   6,  0, 1);
        tab[14] = mk(0, 1, 1, 2,    2,   6,  0, 0);
        tab[15] = mk(0, 1, 0, 0,    3,   2,  1, 0);
        tab[16] = mk(0, 0, 0, 0,    3,   2,  1, 0);
        tab[17] = mk(0, 0, 1, 20,   20,  2,  0, 0);
        tab[18] = mk(0, 1, 0, 0,    21,  20, 1, 0);
        tab[19] = mk(0, 1, 0, 0,    22,  21, 1, 0);
        tab[20] = mk(1, 1, 1, 9,    1,   0,  0, 0);
        tab[21] = mk(0, 1, 1, 9,    1,   0,  0, 0);
        tab[22] = mk(0, 1, 0, 0,    2,   1,  1, 0);

        // Directed table: startup, stall, hlt, redirects, reset with redirect
        for (int i = 0; i < 23; i++) begin
            reset = tab[i].rst; pronto = tab[i].pr; desvio = tab[i].dv;
            alvo_desvio = tab[i].alvo;
            tick();
            exp_ins = (tab[i].e_pcat == 32'd0) ? 32'd0 : mem_word(tab[i].e_pcat, 32'd6, 1'b0);
            chk($sformatf("vec%0d endereco", i), endereco, tab[i].e_end);
            chk($sformatf("vec%0d pc_atual", i), pc_atual, tab[i].e_pcat);
            chk($sformatf("vec%0d valido", i), {31'd0, valido}, {31'd0, tab[i].e_v});
            chk($sformatf("vec%0d parado", i), {31'd0, parado}, {31'd0, tab[i].e_par});
            chk($sformatf("vec%0d instrucao", i), instrucao, exp_ins);
        end

        // PC wraps from all-ones to zero
        reset = 1'b1; desvio = 1'b0; pronto = 1'b1; tick();
        reset = 1'b0; tick();
        desvio = 1'b1; alvo_desvio = 32'hFFFF_FFFF; tick();
        chk("wrap redirect endereco", endereco, 32'hFFFF_FFFF);
        desvio = 1'b0; tick();
        chk("wrap endereco", endereco, 32'd0);
        chk("wrap pc_atual", pc_atual, 32'hFFFF_FFFF);
        chk("wrap instrucao", instrucao, mem_word(32'hFFFF_FFFF, 32'd6, 1'b0));
        tick();
        chk("wrap next endereco", endereco, 32'd1);
        chk("wrap next pc_atual", pc_atual, 32'd0);

        // Randomized run against the reference model
        hlt_addr = 32'h7FFF_FFFF; hlt_rand = 1'b1;
        reset = 1'b1; pronto = 1'b0; desvio = 1'b0;
        model_step(1'b1, 1'b0, 1'b0, 32'd0);
        tick();
        for (int c = 0; c < 800; c++) begin
            reset  = ($urandom_range(0, 99) == 0);
            pronto = ($urandom_range(0, 3) != 0);
            desvio = ($urandom_range(0, 11) == 0);
            alvo_desvio = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                       : 32'($urandom_range(0, 60));
            model_step(reset, pronto, desvio, alvo_desvio);
            tick();
            chk($sformatf("rnd%0d endereco", c), endereco, m_pc);
            chk($sformatf("rnd%0d valido", c), {31'd0, valido}, {31'd0, m_v});
            chk($sformatf("rnd%0d parado", c), {31'd0, parado}, (m_st == 2) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d pc_atual", c), pc_atual, m_pcat);
            chk($sformatf("rnd%0d instrucao", c), instrucao, m_ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unidade_de_busca.md
# unidade_de_busca

Instruction-fetch stage that sits directly upstream of the instruction memory and feeds its fetched words to the decode stage. It owns the program counter, drives the memory address, and captures each returned word into an instruction register. It exposes a valid/ready handshake toward decode. It also accepts branch redirects from execute and stops fetching when it fetches a `hlt`.

## Interface
Parameters:
- `LARGURA_END`, 32: address and PC width.
- `PC_INICIAL`, 1: first word address fetched after reset.
- `OPCODE_HLT`, 5'd18: opcode (bits [31:27]) that halts fetch.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `endereco`  out  `LARGURA_END`  word address to the instruction memory; equals the PC register.
- `instrucao_mem`  in  32  word returned combinationally by the memory for `endereco`.
- `instrucao`  out  32  instruction register presented to decode.
- `pc_atual`  out  `LARGURA_END`  address the current `instrucao` was fetched from.
- `valido`  out  1  `instrucao`/`pc_atual` hold a live instruction.
- `pronto`  in  1  decode accepts `instrucao` this cycle.
- `desvio`  in  1  redirect request from execute.
- `alvo_desvio`  in  `LARGURA_END`  redirect target address.
- `parado`  out  1  fetch is halted.

## Operation
- States:
  - INICIO: one idle cycle after reset, so the instruction memory can complete its first-clock initialisation.
  - BUSCA: fetching.
  - PARADO: halted.
- Reset values: `pc` = `PC_INICIAL`; `instrucao` = 0; `pc_atual` = 0; `valido` = 0; `parado` = 0; state INICIO.
- INICIO -> BUSCA unconditionally; no capture happens in INICIO.
- BUSCA, when `!valido || pronto` (register empty or being consumed):
  - `instrucao` <= `instrucao_mem`, `pc_atual` <= `pc`, `valido` <= 1.
  - If `instrucao_mem[31:27] == OPCODE_HLT`: `pc` is held and the next state is PARADO. The `hlt` word itself is still delivered to decode.
  - Otherwise `pc` <= `pc + 1`, modulo 2^`LARGURA_END` (wraps silently from all-ones to 0).
- BUSCA, when `valido && !pronto`: stall. `pc`, `instrucao`, `pc_atual` and `valido` are all held.
- PARADO:
  - No captures; `parado` = 1.
  - `valido` clears on the cycle the held `hlt` is accepted (`pronto` = 1), then stays 0.
  - Only `reset` or `desvio` leaves PARADO.
- `desvio` (any state except INICIO) has highest priority:
  - `pc` <= `alvo_desvio`, `valido` <= 0 (the in-flight word is flushed, whatever `pronto` is), next state BUSCA.
  - No capture happens in the redirect cycle.
  - A `desvio` arriving in PARADO cancels the halt, since the branch is older than the `hlt`.
- `desvio` during INICIO is ignored.
- `reset` overrides everything, including a simultaneous `desvio`.

## Timing
- `endereco` is combinational from the `pc` register. A word fetched at `pc` appears on `instrucao` one cycle later, with `valido` = 1.
- First valid instruction: `valido` rises at the end of the second clock after `reset` deasserts (one cycle in INICIO, then the capture).
- Sustained throughput: one instruction per cycle while `pronto` = 1.
- Redirect penalty: after `desvio` in cycle N, the word at `alvo_desvio` is valid in cycle N+2.
- `parado` rises in the cycle after the `hlt` is captured.
- Handshake: once asserted, `valido` stays high and `instrucao`/`pc_atual` stay stable until `pronto` or `desvio`.

## Structure
- Shared package holds: the opcode constants (`OPCODE_HLT` = 18 and the rest of the ISA opcodes), the field positions (opcode [31:27], register field [26:22]) and the state encoding (INICIO, BUSCA, PARADO).
- Single module with no sub-modules. The PC register, instruction register and three-state FSM fit in one file.

## Test plan
- Reset, then memory returning distinct words at addresses 1..5, `pronto` held at 1:
  - `endereco` steps 1,2,3,…
  - `instrucao` lags `endereco` by one cycle.
  - `pc_atual` = 1 on the first valid cycle.
- `pronto` = 0 for 3 cycles while `valido` = 1:
  - `instrucao`, `pc_atual` and `endereco` are frozen.
  - The next word is captured on the cycle `pronto` returns to 1.
- Word {5'd18, 27'd0} fetched at address 6:
  - It is delivered with `pc_atual` = 6, then `parado` = 1.
  - `endereco` stays 6.
  - `valido` drops after acceptance and no further captures occur.
- `desvio` = 1 with `alvo_desvio` = 20 while `valido` = 1 and `pronto` = 0:
  - `valido` = 0 next cycle.
  - Next valid instruction has `pc_atual` = 20, then 21.
- Halted at address 6, then `desvio` to 2: `parado` clears and fetch resumes at 2.
- `pc` = 32'hFFFFFFFF, non-hlt word: next `endereco` = 0.
- `reset` asserted mid-stream together with `desvio`:
  - `valido` = 0, `endereco` = 1.
  - One idle INICIO cycle, then fetch from address 1.
